// File: rtl/dma_bus_scheduler.sv
// DMA bus scheduler: copies LENGTH bytes from {src_hi,idx}
// to OAM_BASE+idx, owning the shared memory bus meanwhile.
module dma_bus_scheduler #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          LENGTH       = 160
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_A,
  input  logic [7:0]  cpu_Do,
  input  logic        cpu_wr_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_cs_n,
  output logic [7:0]  cpu_Di,
  output logic [15:0] mem_A,
  output logic [7:0]  mem_Do,
  output logic        mem_wr_n,
  output logic        mem_rd_n,
  output logic        mem_cs_n,
  input  logic [7:0]  mem_Di,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(LENGTH - 1);

  state_t     state_q, state_d;
  logic [7:0] src_hi_q, src_hi_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] latch_q, latch_d;
  logic       prev_wr_q, prev_wr_d;

  logic reg_hit;
  logic reg_wr;
  logic trigger;

  assign reg_hit = !cpu_cs_n && (cpu_A == DMA_REG_ADDR);
  assign reg_wr  = reg_hit && !cpu_wr_n;
  assign trigger = reg_wr && !prev_wr_q;

  // State register and transfer bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      src_hi_q  <= 8'h00;
      idx_q     <= 8'h00;
      latch_q   <= 8'h00;
      prev_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_hi_q  <= src_hi_d;
      idx_q     <= idx_d;
      latch_q   <= latch_d;
      prev_wr_q <= prev_wr_d;
    end
  end

  // Next state: read/write alternation; a fresh trigger restarts
  always_comb begin
    state_d   = state_q;
    src_hi_d  = src_hi_q;
    idx_d     = idx_q;
    latch_d   = latch_q;
    prev_wr_d = reg_wr;
    unique case (state_q)
      READ: begin
        latch_d = mem_Di;
        state_d = WRITE;
      end
      WRITE: begin
        if (idx_q == LAST) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: ;
    endcase
    if (trigger) begin
      src_hi_d = cpu_Do;
      idx_d    = 8'h00;
      state_d  = READ;
    end
  end

  // Bus mux: DMA owns the bus outside IDLE, else CPU pass-through
  always_comb begin
    mem_A    = cpu_A;
    mem_Do   = cpu_Do;
    mem_wr_n = cpu_wr_n;
    mem_rd_n = cpu_rd_n;
    mem_cs_n = cpu_cs_n | reg_hit;
    cpu_Di   = 8'hFF;
    unique case (state_q)
      READ: begin
        mem_A    = {src_hi_q, idx_q};
        mem_cs_n = 1'b0;
        mem_rd_n = 1'b0;
        mem_wr_n = 1'b1;
      end
      WRITE: begin
        mem_A    = OAM_BASE + {8'h00, idx_q};
        mem_Do   = latch_q;
        mem_cs_n = 1'b0;
        mem_wr_n = 1'b0;
        mem_rd_n = 1'b1;
      end
      default: cpu_Di = mem_Di;
    endcase
    if (reg_hit && !cpu_rd_n) begin
      cpu_Di = src_hi_q;
    end
  end

  assign dma_active = (state_q != IDLE);

endmodule

// File: tb/tb_dma_bus_scheduler.sv
// Directed bench for dma_bus_scheduler: default build plus
// a LENGTH=1 build sharing clock, reset and CPU bus.
module tb_dma_bus_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_A = 16'h0000;
  logic [7:0]  cpu_Do = 8'h00;
  logic        cpu_wr_n = 1'b1;
  logic        cpu_rd_n = 1'b1;
  logic        cpu_cs_n = 1'b1;
  logic        cs1_n = 1'b1;
  logic [7:0]  cpu_Di, cpu_Di1;
  logic [15:0] mem_A, mem_A1;
  logic [7:0]  mem_Do, mem_Do1;
  logic        mem_wr_n, mem_rd_n, mem_cs_n;
  logic        mem_wr_n1, mem_rd_n1, mem_cs_n1;
  logic [7:0]  mem_Di, mem_Di1;
  logic        dma_active, dma_active1;

  int total = 0;
  int bad = 0;
  int act = 0;
  int act1 = 0;
  logic [15:0] rd_a[$];
  logic [15:0] wr_a[$];
  logic [7:0]  wr_d[$];
  logic [15:0] rd1_a[$];
  logic [15:0] wr1_a[$];
  logic [7:0]  wr1_d[$];

  function automatic logic [7:0] f(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign mem_Di  = f(mem_A);
  assign mem_Di1 = f(mem_A1);

  dma_bus_scheduler dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_A(cpu_A), .cpu_Do(cpu_Do),
    .cpu_wr_n(cpu_wr_n), .cpu_rd_n(cpu_rd_n),
    .cpu_cs_n(cpu_cs_n), .cpu_Di(cpu_Di),
    .mem_A(mem_A), .mem_Do(mem_Do),
    .mem_wr_n(mem_wr_n), .mem_rd_n(mem_rd_n),
    .mem_cs_n(mem_cs_n), .mem_Di(mem_Di),
    .dma_active(dma_active)
  );

  dma_bus_scheduler #(.LENGTH(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .cpu_A(cpu_A), .cpu_Do(cpu_Do),
    .cpu_wr_n(cpu_wr_n), .cpu_rd_n(cpu_rd_n),
    .cpu_cs_n(cs1_n), .cpu_Di(cpu_Di1),
    .mem_A(mem_A1), .mem_Do(mem_Do1),
    .mem_wr_n(mem_wr_n1), .mem_rd_n(mem_rd_n1),
    .mem_cs_n(mem_cs_n1), .mem_Di(mem_Di1),
    .dma_active(dma_active1)
  );

  always #5 clock = ~clock;

  // Bus monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (!mem_cs_n && !mem_rd_n && dma_active) rd_a.push_back(mem_A);
    if (!mem_cs_n && !mem_wr_n) begin
      wr_a.push_back(mem_A);
      wr_d.push_back(mem_Do);
    end
    if (dma_active) act++;
    if (!mem_cs_n1 && !mem_rd_n1 && dma_active1) rd1_a.push_back(mem_A1);
    if (!mem_cs_n1 && !mem_wr_n1) begin
      wr1_a.push_back(mem_A1);
      wr1_d.push_back(mem_Do1);
    end
    if (dma_active1) act1++;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_a.delete(); wr_a.delete(); wr_d.delete();
    act = 0;
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (dma_active && n < 2000) begin
      @(negedge clock); #1; n++;
    end
    chk({tag, "_timeout"}, 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_act(int target);
    int n = 0;
    while (act < target && n < 2000) begin
      @(negedge clock); #1; n++;
    end
    chk("wait_act_timeout", 32'(act), 32'(target));
  endtask

  task automatic cpu_idle();
    cpu_cs_n = 1'b1; cpu_wr_n = 1'b1; cpu_rd_n = 1'b1;
  endtask

  task automatic pulse_write(logic [7:0] d);
    cpu_A = 16'hFF46; cpu_Do = d;
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_rd_n = 1'b1;
    @(negedge clock); #1;
    cpu_idle();
  endtask

  initial begin
    int nr;
    // Reset state
    #3;
    chk("rst_active", 32'(dma_active), 32'd0);
    cpu_A = 16'hFF46; cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    chk("rst_src_read", 32'(cpu_Di), 32'h00);
    chk("rst_reg_cs", 32'(mem_cs_n), 32'd1);
    cpu_idle();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock); #1;

    // IDLE pass-through
    cpu_A = 16'hC000; cpu_Do = 8'h55;
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
    #1;
    chk("pt_addr", 32'(mem_A), 32'hC000);
    chk("pt_data", 32'(mem_Do), 32'h55);
    chk("pt_wr", 32'(mem_wr_n), 32'd0);
    chk("pt_cs", 32'(mem_cs_n), 32'd0);
    cpu_wr_n = 1'b1; cpu_rd_n = 1'b0;
    #1;
    chk("pt_rd_data", 32'(cpu_Di), 32'(f(16'hC000)));
    chk("pt_rd", 32'(mem_rd_n), 32'd0);
    cpu_idle();
    @(negedge clock); #1;
    clear_logs();

    // Full transfer from C100, write held 8 cycles
    cpu_A = 16'hFF46; cpu_Do = 8'hC1;
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
    #1;
    chk("trig_cs_blocked", 32'(mem_cs_n), 32'd1);
    chk("trig_not_yet", 32'(dma_active), 32'd0);
    repeat (8) @(negedge clock);
    #1;
    cpu_idle();
    chk("xfer_active", 32'(dma_active), 32'd1);
    wait_idle("xfer");
    chk("xfer_act_cycles", 32'(act), 32'd320);
    chk("xfer_nreads", 32'(rd_a.size()), 32'd160);
    chk("xfer_nwrites", 32'(wr_a.size()), 32'd160);
    nr = (rd_a.size() < 160) ? rd_a.size() : 160;
    for (int i = 0; i < nr; i++)
      chk("xfer_rd_addr", 32'(rd_a[i]), 32'(16'hC100 + 16'(i)));
    nr = (wr_a.size() < 160) ? wr_a.size() : 160;
    for (int i = 0; i < nr; i++) begin
      chk("xfer_wr_addr", 32'(wr_a[i]), 32'(16'hFE00 + 16'(i)));
      chk("xfer_wr_data", 32'(wr_d[i]),
          32'(f(16'hC100 + 16'(i))));
    end

    // Register readback, never forwarded
    cpu_A = 16'hFF46; cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    chk("reg_read", 32'(cpu_Di), 32'hC1);
    chk("reg_read_cs", 32'(mem_cs_n), 32'd1);
    @(negedge clock); #1;
    chk("reg_read_cs2", 32'(mem_cs_n), 32'd1);
    chk("reg_read_noact", 32'(dma_active), 32'd0);
    cpu_idle();
    @(negedge clock); #1;
    clear_logs();

    // CPU blocked during DMA
    pulse_write(8'hC1);
    repeat (5) @(negedge clock);
    #1;
    cpu_A = 16'hC000; cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    chk("blk_rd_ff", 32'(cpu_Di), 32'hFF);
    cpu_rd_n = 1'b1; cpu_wr_n = 1'b0; cpu_Do = 8'hAA;
    repeat (2) @(negedge clock);
    #1;
    cpu_idle();
    wait_idle("blk");
    begin
      int hits = 0;
      for (int i = 0; i < wr_a.size(); i++)
        if (wr_a[i] == 16'hC000) hits++;
      chk("blk_no_c000_wr", 32'(hits), 32'd0);
    end
    chk("blk_nwrites", 32'(wr_a.size()), 32'd160);
    @(negedge clock); #1;
    clear_logs();

    // Restart at byte 50
    pulse_write(8'hC1);
    wait_act(100);
    cpu_A = 16'hFF46; cpu_Do = 8'hD0;
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
    @(negedge clock); #1;
    cpu_idle();
    wait_idle("rst50");
    chk("rst50_act", 32'(act), 32'd420);
    chk("rst50_nreads", 32'(rd_a.size()), 32'd210);
    if (rd_a.size() == 210) begin
      chk("rst50_rd49", 32'(rd_a[49]), 32'hC131);
      chk("rst50_rd50", 32'(rd_a[50]), 32'hD000);
      chk("rst50_rdlast", 32'(rd_a[209]), 32'hD09F);
    end
    chk("rst50_nwrites", 32'(wr_a.size()), 32'd210);
    if (wr_a.size() == 210) begin
      chk("rst50_wr50", 32'(wr_a[50]), 32'hFE00);
      chk("rst50_wd50", 32'(wr_d[50]), 32'(f(16'hD000)));
      chk("rst50_wrlast", 32'(wr_a[209]), 32'hFE9F);
    end
    @(negedge clock); #1;
    clear_logs();

    // Reset abort at byte 80
    pulse_write(8'hC1);
    wait_act(160);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_active", 32'(dma_active), 32'd0);
    chk("abort_cs", 32'(mem_cs_n), 32'd1);
    chk("abort_wr", 32'(mem_wr_n), 32'd1);
    clear_logs();
    repeat (3) @(negedge clock);
    #2;
    reset_n = 1'b1;
    repeat (400) @(negedge clock);
    #1;
    chk("abort_no_wr", 32'(wr_a.size()), 32'd0);
    chk("abort_no_act", 32'(act), 32'd0);
    cpu_A = 16'hFF46; cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    chk("abort_src_read", 32'(cpu_Di), 32'h00);
    cpu_idle();
    @(negedge clock); #1;

    // LENGTH=1 build
    rd1_a.delete(); wr1_a.delete(); wr1_d.delete();
    act1 = 0;
    cpu_A = 16'hFF46; cpu_Do = 8'h80;
    cs1_n = 1'b0; cpu_wr_n = 1'b0;
    @(negedge clock); #1;
    cs1_n = 1'b1; cpu_wr_n = 1'b1;
    repeat (10) @(negedge clock);
    #1;
    chk("l1_act", 32'(act1), 32'd2);
    chk("l1_nreads", 32'(rd1_a.size()), 32'd1);
    chk("l1_nwrites", 32'(wr1_a.size()), 32'd1);
    if (rd1_a.size() == 1)
      chk("l1_rd_addr", 32'(rd1_a[0]), 32'h8000);
    if (wr1_a.size() == 1) begin
      chk("l1_wr_addr", 32'(wr1_a[0]), 32'hFE00);
      chk("l1_wr_data", 32'(wr1_d[0]), 32'(f(16'h8000)));
    end
    chk("l1_main_idle", 32'(act), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_bus_scheduler.md
DMA_BUS_SCHEDULER -- requirements
Module: dma_bus_scheduler

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'hFF46, CPU-visible DMA source/trigger register address.
REQ-002 SHALL have parameter OAM_BASE, default 16'hFE00, destination base address.
REQ-003 SHALL have parameter LENGTH, default 160, bytes per transfer (1..256).
REQ-004 SHALL have port clock  in  1  single core clock; every register updates on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports cpu_A  in  16, cpu_Do  in  8, cpu_wr_n/cpu_rd_n/cpu_cs_n  in  1 each: CPU-side bus request, strobes active-low.
REQ-007 SHALL have port cpu_Di  out  8  read data returned to the CPU.
REQ-008 SHALL have ports mem_A  out  16, mem_Do  out  8, mem_wr_n/mem_rd_n/mem_cs_n  out  1 each: shared memory bus (cartridge/WRAM/OAM), async read, write sampled on clock edge.
REQ-009 SHALL have port mem_Di  in  8  memory read data, valid combinationally in the same cycle.
REQ-010 SHALL have port dma_active  out  1  high while the scheduler owns the memory bus.

Function
REQ-011 SHALL keep state IDLE, READ or WRITE, an 8-bit source register src_hi, an 8-bit index idx, an 8-bit data latch, and a 1-bit prev_wr sample.
REQ-012 SHALL define reg_hit = !cpu_cs_n && cpu_A==DMA_REG_ADDR; reg_wr = reg_hit && !cpu_wr_n; prev_wr <= reg_wr every cycle.
REQ-013 SHALL trigger only on the edge where reg_wr==1 and prev_wr==0 (a CPU write held for many cycles triggers once).
REQ-014 On trigger, in any state: src_hi <= cpu_Do, idx <= 0, state <= READ (a write during DMA restarts from byte 0 with the new source).
REQ-015 READ: mem_A={src_hi,idx}, mem_cs_n=0, mem_rd_n=0, mem_wr_n=1; at the edge latch <= mem_Di, state <= WRITE.
REQ-016 WRITE: mem_A=OAM_BASE+idx, mem_Do=latch, mem_cs_n=0, mem_wr_n=0, mem_rd_n=1; at the edge, if idx==LENGTH-1 state <= IDLE, else idx <= idx+1, state <= READ.
REQ-017 A transfer SHALL take exactly 2*LENGTH cycles (320 at default) from the trigger edge to the edge returning to IDLE.
REQ-018 dma_active SHALL be 1 exactly when state != IDLE (registered state, no combinational path from cpu inputs).
REQ-019 In IDLE, mem_A/mem_Do/mem_wr_n/mem_rd_n/mem_cs_n SHALL equal cpu_A/cpu_Do/cpu_wr_n/cpu_rd_n/cpu_cs_n, except mem_cs_n=1 when reg_hit.
REQ-020 cpu_Di SHALL be src_hi when reg_hit and !cpu_rd_n (any state); otherwise mem_Di in IDLE; otherwise 8'hFF.
REQ-021 While dma_active, CPU accesses other than reg_hit SHALL not reach the memory bus; CPU writes are dropped, reads return 8'hFF.
REQ-022 Accesses to DMA_REG_ADDR SHALL never be forwarded to the memory bus.
REQ-023 src_hi SHALL be used unmodified; source addresses {src_hi,8'h00}..{src_hi,LENGTH-1} with no wrap beyond the low byte.

Reset
REQ-024 reset_n low SHALL immediately force state=IDLE, src_hi=8'h00, idx=0, latch=8'h00, prev_wr=0, dma_active=0.
REQ-025 Reset asserted mid-transfer SHALL abort it; no further DMA write strobes after reset assertion; bus reverts to CPU pass-through.
REQ-026 After reset release, no transfer SHALL start until a new rising reg_wr edge (a write held through reset release counts only if prev_wr=0, i.e. triggers on the first edge).

Verification
REQ-027 Write 8'hC1 to 16'hFF46 (wr_n low 8 cycles) -> one transfer; 160 reads at C100..C19F, 160 writes at FE00..FE9F with matching data; dma_active high 320 cycles.
REQ-028 Read 16'hFF46 after REQ-027 -> cpu_Di=8'hC1; mem_cs_n stays 1 during the access.
REQ-029 CPU read of 16'hC000 during DMA -> cpu_Di=8'hFF; CPU write to 16'hC000 during DMA -> no memory write at C000 with cpu data.
REQ-030 Second write 8'hD0 at byte 50 of a transfer -> next read at D000, full 160 bytes from D000, total active time 100+320 cycles.
REQ-031 reset_n low at byte 80 -> dma_active=0 immediately, no mem_wr_n low until next trigger; FF46 reads 8'h00.
REQ-032 LENGTH=1 build, trigger with 8'h80 -> single read 8000, single write FE00, dma_active high 2 cycles.
